// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU controller: FSM states,
// instruction-word field positions and the decoded C-instruction view.
package hack_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MREAD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MWRITE = 3'd4
    } state_e;

    // Instruction word layout.
    localparam int ISA_C_BIT = 15;
    localparam int A_BIT     = 12;
    localparam int CTL_MSB   = 11;
    localparam int CTL_LSB   = 6;
    localparam int DEST_A    = 5;
    localparam int DEST_D    = 4;
    localparam int DEST_M    = 3;
    localparam int J_LT      = 2;
    localparam int J_EQ      = 1;
    localparam int J_GT      = 0;

    // Decoded view of the instruction register.
    typedef struct packed {
        logic       is_c;
        logic       a;
        logic [5:0] ctl;
        logic       dest_a;
        logic       dest_d;
        logic       dest_m;
        logic [2:0] jmp;
    } c_fields_t;

    // Sequential program counter step; wraps 16'hFFFF to 16'h0000.
    function automatic logic [15:0] pc_next(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition evaluation from the three jump bits and the ALU flags.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0] j_bits,
    input  logic       zr,
    input  logic       ng,
    output logic       jmp
);

    // "Greater than zero" means neither negative nor zero.
    always_comb begin
        jmp = (j_bits[J_LT] & ng) |
              (j_bits[J_EQ] & zr) |
              (j_bits[J_GT] & ~ng & ~zr);
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller. Owns A, D and PC, sequences
// fetch / optional M read / execute / optional M write, and drives an
// external Hack ALU with operands and control bits.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [15:0] instr_addr,
    input  logic [15:0] instr_rdata,
    input  logic        instr_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [15:0] pc_out
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] res_q, res_d;
    logic        jmp_q, jmp_d;

    c_fields_t   ir_f_s;
    logic        jmp_s;
    logic [15:0] pc_inc_s;
    logic [15:0] commit_res_s;
    logic        commit_jmp_s;
    logic [15:0] a_commit_s;
    logic [15:0] d_commit_s;
    logic [15:0] pc_commit_s;
    logic        instr_req_s;
    logic        mem_req_s;
    logic        mem_we_s;

    // Split the instruction register into its C-instruction fields.
    always_comb begin
        ir_f_s.is_c   = ir_q[ISA_C_BIT];
        ir_f_s.a      = ir_q[A_BIT];
        ir_f_s.ctl    = ir_q[CTL_MSB:CTL_LSB];
        ir_f_s.dest_a = ir_q[DEST_A];
        ir_f_s.dest_d = ir_q[DEST_D];
        ir_f_s.dest_m = ir_q[DEST_M];
        ir_f_s.jmp    = ir_q[J_LT:J_GT];
    end

    hack_jump_eval u_jump_eval (
        .j_bits (ir_f_s.jmp),
        .zr     (alu_zr),
        .ng     (alu_ng),
        .jmp    (jmp_s)
    );

    // Writeback values: EXEC commits straight from the ALU, MWRITE commits
    // the result and jump decision captured in EXEC. The jump target is the
    // A value from before this instruction's own update.
    always_comb begin
        pc_inc_s = pc_next(pc_q);
        if (state_q == ST_MWRITE) begin
            commit_res_s = res_q;
            commit_jmp_s = jmp_q;
        end else begin
            commit_res_s = alu_out;
            commit_jmp_s = jmp_s;
        end
        if (ir_f_s.dest_a) begin
            a_commit_s = commit_res_s;
        end else begin
            a_commit_s = a_q;
        end
        if (ir_f_s.dest_d) begin
            d_commit_s = commit_res_s;
        end else begin
            d_commit_s = d_q;
        end
        if (commit_jmp_s) begin
            pc_commit_s = a_q;
        end else begin
            pc_commit_s = pc_inc_s;
        end
    end

    // Next-state and register update logic for the fetch/read/exec/write sequence.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        d_d         = d_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        res_d       = res_q;
        jmp_d       = jmp_q;
        instr_req_s = 1'b0;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req_s = 1'b1;
                if (instr_ack) begin
                    ir_d    = instr_rdata;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!ir_f_s.is_c) begin
                    a_d     = ir_q;
                    pc_d    = pc_inc_s;
                    state_d = ST_FETCH;
                end else if (ir_f_s.a) begin
                    state_d = ST_MREAD;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MREAD: begin
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_MREAD;
                end
            end
            ST_EXEC: begin
                res_d = alu_out;
                if (!ir_f_s.dest_m) begin
                    a_d     = a_commit_s;
                    d_d     = d_commit_s;
                    pc_d    = pc_commit_s;
                    state_d = ST_FETCH;
                end else begin
                    jmp_d   = jmp_s;
                    state_d = ST_MWRITE;
                end
            end
            ST_MWRITE: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                if (mem_ack) begin
                    a_d     = a_commit_s;
                    d_d     = d_commit_s;
                    pc_d    = pc_commit_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MWRITE;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Architectural and pipeline registers; reset discards any partial instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            a_q     <= 16'h0000;
            d_q     <= 16'h0000;
            ir_q    <= 16'h0000;
            mdr_q   <= 16'h0000;
            res_q   <= 16'h0000;
            jmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            res_q   <= res_d;
            jmp_q   <= jmp_d;
        end
    end

    // The state register resets to FETCH, so the fetch request is also
    // qualified by rst_n to keep it low while reset is held.
    assign instr_req  = instr_req_s & rst_n;
    assign instr_addr = pc_q;
    assign mem_req    = mem_req_s;
    assign mem_we     = mem_we_s;
    assign mem_addr   = a_q;
    assign mem_wdata  = res_q;
    assign pc_out     = pc_q;

    // ALU operands and controls come from registers in every state.
    assign alu_x  = d_q;
    assign alu_y  = ir_f_s.a ? mdr_q : a_q;
    assign alu_zx = ir_f_s.ctl[5];
    assign alu_nx = ir_f_s.ctl[4];
    assign alu_zy = ir_f_s.ctl[3];
    assign alu_ny = ir_f_s.ctl[2];
    assign alu_f  = ir_f_s.ctl[1];
    assign alu_no = ir_f_s.ctl[0];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: environment ROM/RAM/ALU plus an instruction-level
// Hack model that predicts fetch addresses, D, and every data access.
`timescale 1ns/1ps
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, instr_ack;
    logic [15:0] instr_addr, instr_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [15:0] pc_out;

    hack_cpu_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_rdata(instr_rdata), .instr_ack(instr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic [15:0] rom  [0:255];
    logic [15:0] ram  [0:65535];
    logic [15:0] mram [0:65535];
    logic [15:0] m_a, m_d, m_pc;
    acc_t        exp_q[$];
    acc_t        mem_log[$];
    logic [15:0] fetch_addr_log[$];
    logic [15:0] fetch_d_log[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          i_lo = 0, i_hi = 0, m_lo = 0, m_hi = 0;
    bit          spur_en = 1'b0;
    bit          hold_wr = 1'b0;
    int          i_w = -1, i_cnt = 0, m_w = -1, m_cnt = 0;

    // Hack ALU as arithmetic on the six control bits.
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    // Environment ALU responding to the controller's operands.
    always_comb begin
        alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-instruction model: applies the instruction to A/D/PC/RAM and
    // queues the data accesses the controller must perform for it.
    task automatic model_step(input logic [15:0] w);
        logic [15:0] y, r;
        logic        take;
        acc_t        e;
        if (w[15] == 1'b0) begin
            m_a  = w;
            m_pc = m_pc + 16'd1;
        end else begin
            if (w[12]) begin
                y = mram[m_a];
                e.we = 1'b0; e.addr = m_a; e.data = y;
                exp_q.push_back(e);
            end else begin
                y = m_a;
            end
            r = hack_alu(m_d, y, w[11:6]);
            if (w[3]) begin
                e.we = 1'b1; e.addr = m_a; e.data = r;
                exp_q.push_back(e);
                mram[m_a] = r;
            end
            take = (w[2] && ($signed(r) < 0)) || (w[1] && (r == 16'h0000)) ||
                   (w[0] && ($signed(r) > 0));
            m_pc = take ? m_a : (m_pc + 16'd1);
            if (w[5]) m_a = r;
            if (w[4]) m_d = r;
        end
    endtask

    task automatic reset_model();
        m_a = 16'h0000; m_d = 16'h0000; m_pc = 16'h0000;
        exp_q.delete(); mem_log.delete();
        fetch_addr_log.delete(); fetch_d_log.delete();
        for (int i = 0; i < 65536; i++) mram[i] = ram[i];
    endtask

    // Memory responder and per-cycle compare against the model.
    always @(negedge clk) begin : resp
        acc_t e;
        acc_t l;
        instr_ack = 1'b0;
        mem_ack   = 1'b0;
        if (!rst_n) begin
            chk1("rst_instr_req", instr_req, 1'b0);
            chk1("rst_mem_req", mem_req, 1'b0);
            chk16("rst_pc", pc_out, 16'h0000);
            i_w = -1; i_cnt = 0; m_w = -1; m_cnt = 0;
        end else begin
            if (instr_req) begin
                chk16("fetch_addr", instr_addr, m_pc);
                chk16("pc_out", pc_out, m_pc);
                chk16("d_reg", alu_x, m_d);
                chk1("req_exclusive", mem_req, 1'b0);
                if (i_w < 0) begin
                    i_w = int'($urandom_range(i_hi, i_lo));
                    i_cnt = 0;
                end
                if (i_cnt >= i_w) begin
                    instr_ack   = 1'b1;
                    instr_rdata = rom[instr_addr[7:0]];
                    fetch_addr_log.push_back(instr_addr);
                    fetch_d_log.push_back(alu_x);
                    model_step(instr_rdata);
                    i_w = -1;
                end else begin
                    i_cnt++;
                end
            end else if (spur_en && $urandom_range(3, 0) == 0) begin
                instr_ack   = 1'b1;
                instr_rdata = 16'($urandom);
            end
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_mem_req: got addr %h we %b expected no access",
                             mem_addr, mem_we);
                end else begin
                    e = exp_q[0];
                    chk1("mem_we", mem_we, e.we);
                    chk16("mem_addr", mem_addr, e.addr);
                    if (e.we) chk16("mem_wdata", mem_wdata, e.data);
                    if (m_w < 0) begin
                        m_w = int'($urandom_range(m_hi, m_lo));
                        m_cnt = 0;
                    end
                    if (m_cnt >= m_w && !(hold_wr && mem_we)) begin
                        mem_ack = 1'b1;
                        l.we = mem_we; l.addr = mem_addr;
                        if (mem_we) begin
                            ram[mem_addr] = mem_wdata;
                            l.data = mem_wdata;
                        end else begin
                            mem_rdata = ram[mem_addr];
                            l.data = mem_rdata;
                        end
                        mem_log.push_back(l);
                        void'(exp_q.pop_front());
                        m_w = -1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (spur_en && $urandom_range(3, 0) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end
        end
    end

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_prog_rw();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0064;   // @100
        rom[1] = 16'hFDE8;   // AM=M+1
        rom[2] = 16'hEC10;   // D=A
        rom[3] = 16'h0003;   // @3
        rom[4] = 16'hEA87;   // 0;JMP
        ram[100] = 16'd41;
    endtask

    task automatic check_prog_rw(input string tag);
        if (mem_log.size() < 2 || fetch_addr_log.size() < 4) begin
            n_vec++; n_err++;
            $display("FAIL %s_progress: got %0d accesses %0d fetches expected >=2 and >=4",
                     tag, mem_log.size(), fetch_addr_log.size());
        end else begin
            chk1 ({tag, "_rd_we"}, mem_log[0].we, 1'b0);
            chk16({tag, "_rd_addr"}, mem_log[0].addr, 16'd100);
            chk16({tag, "_rd_data"}, mem_log[0].data, 16'd41);
            chk1 ({tag, "_wr_we"}, mem_log[1].we, 1'b1);
            chk16({tag, "_wr_addr"}, mem_log[1].addr, 16'd100);
            chk16({tag, "_wr_data"}, mem_log[1].data, 16'd42);
            chk16({tag, "_d_unchanged"}, fetch_d_log[2], 16'd0);
            chk16({tag, "_fetch3"}, fetch_addr_log[3], 16'd3);
            chk16({tag, "_a_is_42"}, fetch_d_log[3], 16'd42);
        end
    endtask

    initial begin
        logic [15:0] exp_j [0:8];
        bit          found;
        rst_n = 1'b0;
        instr_ack = 1'b0; instr_rdata = 16'h0000;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        for (int i = 0; i < 65536; i++) ram[i] = 16'(i * 7);

        // Reset state and first fetch; @5 then D=A with zero-wait acks.
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0005;
        rom[1] = 16'hEC10;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        chk16("reset_pc", pc_out, 16'h0000);
        chk1("reset_instr_req", instr_req, 1'b0);
        chk1("reset_mem_req", mem_req, 1'b0);
        chk1("reset_mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk1("first_req", instr_req, 1'b1);
        chk16("first_addr", instr_addr, 16'h0000);
        repeat (4) @(negedge clk);
        #1;
        chk16("exec_ctl", {10'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 16'h0030);
        chk16("exec_y_is_a", alu_y, 16'd5);
        chk16("exec_x_is_d", alu_x, 16'd0);
        chk16("model_d", m_d, 16'd5);
        chk16("model_pc", m_pc, 16'd2);
        @(negedge clk); #1;
        chk16("after5_pc", pc_out, 16'd2);
        chk16("after5_d", alu_x, 16'd5);
        chk1("after5_req", instr_req, 1'b1);

        // M read-modify-write, zero wait.
        load_prog_rw();
        apply_reset();
        repeat (40) @(negedge clk);
        #1 check_prog_rw("rmw");

        // Jumps: JEQ taken, JEQ not taken, unconditional.
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]  = 16'hEA90; rom[1]  = 16'h0010; rom[2]  = 16'hE302;
        rom[16] = 16'hEFD0; rom[17] = 16'h0010; rom[18] = 16'hE302;
        rom[19] = 16'h0028; rom[20] = 16'hEA87;
        rom[40] = 16'h0028; rom[41] = 16'hEA87;
        exp_j = '{16'd0, 16'd1, 16'd2, 16'd16, 16'd17, 16'd18, 16'd19, 16'd20, 16'd40};
        apply_reset();
        repeat (40) @(negedge clk);
        #1;
        if (fetch_addr_log.size() < 9) begin
            n_vec++; n_err++;
            $display("FAIL jump_progress: got %0d fetches expected >=9", fetch_addr_log.size());
        end else begin
            for (int i = 0; i < 9; i++) chk16("jump_seq", fetch_addr_log[i], exp_j[i]);
        end

        // Wait states with stray acks: fetch held 4 cycles, then decode.
        i_lo = 3; i_hi = 3; m_lo = 2; m_hi = 2; spur_en = 1'b1;
        load_prog_rw();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk1("wait_req_held", instr_req, 1'b1);
            chk16("wait_addr_held", instr_addr, 16'h0000);
        end
        @(negedge clk); #1;
        chk1("wait_req_dropped", instr_req, 1'b0);
        repeat (50) @(negedge clk);
        #1 check_prog_rw("wait");

        // Reset during MWRITE before the write is acknowledged.
        i_lo = 0; i_hi = 0; m_lo = 0; m_hi = 0; spur_en = 1'b0; hold_wr = 1'b1;
        load_prog_rw();
        apply_reset();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk); #1;
            if (mem_req && mem_we) found = 1'b1;
        end
        chk1("mwrite_reached", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_mem_req", mem_req, 1'b0);
        chk1("midrst_mem_we", mem_we, 1'b0);
        chk1("midrst_instr_req", instr_req, 1'b0);
        chk16("midrst_pc", pc_out, 16'h0000);
        chk16("midrst_d", alu_x, 16'h0000);
        chk16("midrst_writes", 16'(mem_log.size()), 16'd1);
        hold_wr = 1'b0;
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk16("post_rst_fetch", instr_addr, 16'h0000);

        // Randomized programs, random waits and stray acks.
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(1, 0) == 0) rom[i] = {8'h00, 8'($urandom_range(255, 0))};
            else rom[i] = 16'($urandom) | 16'h8000;
        end
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        i_lo = 0; i_hi = 3; m_lo = 0; m_hi = 3; spur_en = 1'b1;
        apply_reset();
        repeat (4000) @(negedge clk);
        #1;
        chk1("random_progress", fetch_addr_log.size() >= 300, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
